// File: rtl/spi_frame_packer.sv
// Packs per-channel SPI samples into fixed-length frames (magic, timestamp, samples).
// Frame length is always 4+N_CHANNELS words; short frames are padded and surplus samples dropped.
module spi_frame_packer #(
  parameter int          N_CHANNELS = 36,
  parameter logic [31:0] MAGIC      = 32'hC691_1999,
  parameter logic [15:0] PAD_WORD   = 16'h8000,
  parameter int          BUF_AW     = 4
) (
  input  logic        spi_clk,
  input  logic        reset,
  input  logic        run,
  input  logic        frame_start,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic [15:0] FIFO_DATA_STREAM,
  output logic        FIFO_DATA_STREAM_WEN,
  output logic [31:0] timestamp,
  output logic        frame_error
);
  localparam logic [7:0]      NCH  = 8'(N_CHANNELS);
  localparam logic [BUF_AW:0] PONE = (BUF_AW+1)'(1);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, TS_LO, TS_HI, SAMP, PAD} state_t;

  state_t state_q, state_d;
  logic [7:0]  acc_cnt_q, acc_cnt_d, emit_cnt_q, emit_cnt_d, cur_lim_q, cur_lim_d;
  logic        win_q, win_d, pend_q, pend_d, err_q, err_d;
  logic [31:0] ts_q, ts_d, pend_stamp_q, pend_stamp_d, cur_stamp_q, cur_stamp_d;
  logic [15:0] dout_q, dout_d;
  logic        wen_q, wen_d;
  logic [BUF_AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [15:0] mem [2**BUF_AW];

  logic start_req, start_acc, start_drop, short_now, in_win, push, pop, take;
  logic empty, full, avail;
  logic [7:0]  lim_eff;
  logic [15:0] pop_data;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[BUF_AW] != rd_q[BUF_AW]) && (wr_q[BUF_AW-1:0] == rd_q[BUF_AW-1:0]);
  // An empty buffer forwards the sample arriving this cycle so it can leave next cycle.
  assign avail    = !empty || push;
  assign pop_data = empty ? sample_data : mem[rd_q[BUF_AW-1:0]];

  assign start_req  = frame_start && run;
  assign start_acc  = start_req && (!pend_q || state_q == IDLE);
  assign start_drop = start_req && !start_acc;
  assign short_now  = start_acc && win_q;
  assign in_win     = start_acc || win_q;
  assign push       = sample_valid && in_win && !full;
  assign take       = (state_q == IDLE) && (pend_q || start_acc);
  // A truncating start shortens the frame in flight in the same cycle, so a
  // forwarded new-frame sample can never be counted against the old frame.
  assign lim_eff    = short_now ? acc_cnt_q : cur_lim_q;

  always_comb begin : accept_path
    acc_cnt_d    = start_acc ? 8'd0 : acc_cnt_q;
    win_d        = start_acc ? 1'b1 : win_q;
    if (push) begin
      acc_cnt_d = acc_cnt_d + 8'd1;
      if (acc_cnt_d == NCH) win_d = 1'b0;
    end
    err_d        = err_q | start_drop | short_now | (sample_valid && (!in_win || full));
    ts_d         = start_acc ? ts_q + 32'd1 : ts_q;
    pend_stamp_d = start_acc ? ts_q : pend_stamp_q;
    pend_d       = pend_q;
    if (take)           pend_d = pend_q && start_acc;
    else if (start_acc) pend_d = 1'b1;
    cur_stamp_d  = cur_stamp_q;
    cur_lim_d    = cur_lim_q;
    if (take) begin
      cur_stamp_d = pend_q ? pend_stamp_q : ts_q;
      cur_lim_d   = NCH;
    end
    if (short_now) cur_lim_d = acc_cnt_q;
    wr_d = push ? wr_q + PONE : wr_q;
  end

  always_ff @(posedge spi_clk or posedge reset) begin : state_reg
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = HDR0;
      HDR0:    state_d = HDR1;
      HDR1:    state_d = TS_LO;
      TS_LO:   state_d = TS_HI;
      TS_HI:   state_d = SAMP;
      SAMP:    if (emit_cnt_q == lim_eff) state_d = (lim_eff < NCH) ? PAD : IDLE;
      PAD:     if (emit_cnt_q == NCH) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so the word is chosen for the state being entered.
  always_comb begin : emit_out
    pop    = 1'b0;
    wen_d  = 1'b0;
    dout_d = 16'h0000;
    case (state_d)
      HDR0:  begin wen_d = 1'b1; dout_d = MAGIC[15:0];        end
      HDR1:  begin wen_d = 1'b1; dout_d = MAGIC[31:16];       end
      TS_LO: begin wen_d = 1'b1; dout_d = cur_stamp_q[15:0];  end
      TS_HI: begin wen_d = 1'b1; dout_d = cur_stamp_q[31:16]; end
      SAMP:  begin
        pop    = avail && (emit_cnt_q < lim_eff);
        wen_d  = pop;
        dout_d = pop ? pop_data : 16'h0000;
      end
      PAD:   begin wen_d = 1'b1; dout_d = PAD_WORD;           end
      default: ;
    endcase
    emit_cnt_d = take ? 8'd0 : emit_cnt_q + 8'((pop || state_d == PAD) ? 1 : 0);
    rd_d       = pop ? rd_q + PONE : rd_q;
  end

  always_ff @(posedge spi_clk or posedge reset) begin : data_regs
    if (reset) begin
      acc_cnt_q <= '0; emit_cnt_q <= '0; cur_lim_q <= NCH;
      win_q <= 1'b0; pend_q <= 1'b0; err_q <= 1'b0;
      ts_q <= '0; pend_stamp_q <= '0; cur_stamp_q <= '0;
      dout_q <= '0; wen_q <= 1'b0; wr_q <= '0; rd_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d; emit_cnt_q <= emit_cnt_d; cur_lim_q <= cur_lim_d;
      win_q <= win_d; pend_q <= pend_d; err_q <= err_d;
      ts_q <= ts_d; pend_stamp_q <= pend_stamp_d; cur_stamp_q <= cur_stamp_d;
      dout_q <= dout_d; wen_q <= wen_d; wr_q <= wr_d; rd_q <= rd_d;
    end
  end

  always_ff @(posedge spi_clk) begin : buf_mem
    if (push) mem[wr_q[BUF_AW-1:0]] <= sample_data;
  end

  assign FIFO_DATA_STREAM     = dout_q;
  assign FIFO_DATA_STREAM_WEN = wen_q;
  assign timestamp            = ts_q;
  assign frame_error          = err_q;
endmodule

// File: tb/tb_spi_frame_packer.sv
// Scoreboard bench for spi_frame_packer with a 4-channel frame.
module tb_spi_frame_packer;
  localparam int N = 4;

  logic        spi_clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b1;
  logic        frame_start = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic [15:0] FIFO_DATA_STREAM;
  logic        FIFO_DATA_STREAM_WEN;
  logic [31:0] timestamp;
  logic        frame_error;

  int errors = 0;
  int checks = 0;
  int wen_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  spi_frame_packer #(.N_CHANNELS(N), .MAGIC(32'hC691_1999), .PAD_WORD(16'h8000), .BUF_AW(4)) dut (
    .spi_clk(spi_clk), .reset(reset), .run(run), .frame_start(frame_start),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .FIFO_DATA_STREAM(FIFO_DATA_STREAM), .FIFO_DATA_STREAM_WEN(FIFO_DATA_STREAM_WEN),
    .timestamp(timestamp), .frame_error(frame_error)
  );

  always #5 spi_clk = ~spi_clk;

  always @(negedge spi_clk) begin
    if (!reset && FIFO_DATA_STREAM_WEN) begin
      wen_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got=%h expected=none", FIFO_DATA_STREAM);
      end else begin
        exp_w = exp_q.pop_front();
        if (FIFO_DATA_STREAM !== exp_w) begin
          errors++;
          $display("FAIL stream_word got=%h expected=%h", FIFO_DATA_STREAM, exp_w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge spi_clk); #1;
  endtask

  task automatic drive(input logic fs, input logic sv, input logic [15:0] d);
    frame_start = fs; sample_valid = sv; sample_data = d;
    tick();
    frame_start = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; frame_start = 1'b0; sample_valid = 1'b0; run = 1'b1;
    tick(); tick();
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic push_hdr(input logic [31:0] stamp);
    exp_q.push_back(16'h1999); exp_q.push_back(16'hC691);
    exp_q.push_back(stamp[15:0]); exp_q.push_back(stamp[31:16]);
  endtask

  task automatic send_frame(input logic [15:0] base);
    push_hdr_dummy();
    drive(1'b1, 1'b1, base + 16'd1);
    for (int k = 2; k <= N; k++) drive(1'b0, 1'b1, base + 16'(k));
  endtask

  task automatic push_hdr_dummy();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain left=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; #1;
    checks += 4;
    if (FIFO_DATA_STREAM !== 16'h0) begin errors++; $display("FAIL reset_data got=%h required=0000", FIFO_DATA_STREAM); end
    if (FIFO_DATA_STREAM_WEN !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b required=0", FIFO_DATA_STREAM_WEN); end
    if (timestamp !== 32'h0) begin errors++; $display("FAIL reset_ts got=%h required=0", timestamp); end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_err got=%b required=0", frame_error); end
    apply_reset();
  endtask

  task automatic test_normal();
    int c0;
    apply_reset();
    c0 = wen_cnt;
    push_hdr(32'd0);
    for (int k = 1; k <= N; k++) exp_q.push_back(16'(k));
    drive(1'b1, 1'b1, 16'h0001);
    checks++;
    if (FIFO_DATA_STREAM_WEN !== 1'b1 || FIFO_DATA_STREAM !== 16'h1999) begin
      errors++;
      $display("FAIL normal_latency got=%b/%h required=1/1999", FIFO_DATA_STREAM_WEN, FIFO_DATA_STREAM);
    end
    for (int k = 2; k <= N; k++) drive(1'b0, 1'b1, 16'(k));
    wait_drain("normal");
    checks += 3;
    if (timestamp !== 32'd1) begin errors++; $display("FAIL normal_ts got=%0d required=1", timestamp); end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL normal_err got=%b required=0", frame_error); end
    if (wen_cnt - c0 !== 8) begin errors++; $display("FAIL normal_words got=%0d required=8", wen_cnt - c0); end
  endtask

  task automatic test_consecutive();
    int c0;
    apply_reset();
    c0 = wen_cnt;
    for (int f = 0; f < 3; f++) begin
      push_hdr(32'(f));
      for (int k = 1; k <= N; k++) exp_q.push_back(16'(16'h0100 * (f + 1) + k));
      drive(1'b1, 1'b1, 16'(16'h0100 * (f + 1) + 1));
      for (int k = 2; k <= N; k++) drive(1'b0, 1'b1, 16'(16'h0100 * (f + 1) + k));
      repeat (4) drive(1'b0, 1'b0, 16'h0);
    end
    wait_drain("consec");
    checks += 3;
    if (wen_cnt - c0 !== 24) begin errors++; $display("FAIL consec_words got=%0d required=24", wen_cnt - c0); end
    if (timestamp !== 32'd3) begin errors++; $display("FAIL consec_ts got=%0d required=3", timestamp); end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL consec_err got=%b required=0", frame_error); end
  endtask

  task automatic test_short();
    apply_reset();
    push_hdr(32'd0);
    exp_q.push_back(16'hAAAA); exp_q.push_back(16'hBBBB);
    exp_q.push_back(16'h8000); exp_q.push_back(16'h8000);
    push_hdr(32'd1);
    for (int k = 1; k <= N; k++) exp_q.push_back(16'(16'h0C00 + k));
    drive(1'b1, 1'b1, 16'hAAAA);
    drive(1'b0, 1'b1, 16'hBBBB);
    checks++;
    if (frame_error !== 1'b0) begin errors++; $display("FAIL short_err_before got=%b required=0", frame_error); end
    drive(1'b1, 1'b1, 16'h0C01);
    for (int k = 2; k <= N; k++) drive(1'b0, 1'b1, 16'(16'h0C00 + k));
    wait_drain("short");
    checks += 2;
    if (frame_error !== 1'b1) begin errors++; $display("FAIL short_err got=%b required=1", frame_error); end
    if (timestamp !== 32'd2) begin errors++; $display("FAIL short_ts got=%0d required=2", timestamp); end
  endtask

  task automatic test_extra();
    apply_reset();
    push_hdr(32'd0);
    for (int k = 1; k <= N; k++) exp_q.push_back(16'(16'h0E00 + k));
    drive(1'b1, 1'b1, 16'h0E01);
    for (int k = 2; k <= N; k++) drive(1'b0, 1'b1, 16'(16'h0E00 + k));
    checks++;
    if (frame_error !== 1'b0) begin errors++; $display("FAIL extra_err_full got=%b required=0", frame_error); end
    drive(1'b0, 1'b1, 16'h0E05);
    checks++;
    if (frame_error !== 1'b1) begin errors++; $display("FAIL extra_err_drop got=%b required=1", frame_error); end
    drive(1'b0, 1'b1, 16'h0E06);
    repeat (4) drive(1'b0, 1'b0, 16'h0);
    push_hdr(32'd1);
    for (int k = 1; k <= N; k++) exp_q.push_back(16'(16'h0F00 + k));
    drive(1'b1, 1'b1, 16'h0F01);
    for (int k = 2; k <= N; k++) drive(1'b0, 1'b1, 16'(16'h0F00 + k));
    wait_drain("extra");
    checks++;
    if (timestamp !== 32'd2) begin errors++; $display("FAIL extra_ts got=%0d required=2", timestamp); end
  endtask

  task automatic test_gating();
    int c0;
    apply_reset();
    c0 = wen_cnt;
    drive(1'b0, 1'b1, 16'h1234);
    repeat (6) tick();
    checks += 2;
    if (frame_error !== 1'b1) begin errors++; $display("FAIL stray_err got=%b required=1", frame_error); end
    if (wen_cnt !== c0) begin errors++; $display("FAIL stray_words got=%0d required=0", wen_cnt - c0); end
    apply_reset();
    c0 = wen_cnt;
    run = 1'b0;
    drive(1'b1, 1'b0, 16'h0);
    repeat (10) tick();
    checks += 3;
    if (timestamp !== 32'd0) begin errors++; $display("FAIL norun_ts got=%0d required=0", timestamp); end
    if (wen_cnt !== c0) begin errors++; $display("FAIL norun_words got=%0d required=0", wen_cnt - c0); end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL norun_err got=%b required=0", frame_error); end
    run = 1'b1;
  endtask

  task automatic test_midreset();
    apply_reset();
    push_hdr(32'd0);
    for (int k = 1; k <= N; k++) exp_q.push_back(16'(16'h0D00 + k));
    drive(1'b1, 1'b1, 16'h0D01);
    for (int k = 2; k <= N; k++) drive(1'b0, 1'b1, 16'(16'h0D00 + k));
    tick(); tick();
    reset = 1'b1; #1;
    checks += 3;
    if (FIFO_DATA_STREAM_WEN !== 1'b0) begin errors++; $display("FAIL midrst_wen got=%b required=0", FIFO_DATA_STREAM_WEN); end
    if (FIFO_DATA_STREAM !== 16'h0) begin errors++; $display("FAIL midrst_data got=%h required=0000", FIFO_DATA_STREAM); end
    if (timestamp !== 32'd0) begin errors++; $display("FAIL midrst_ts got=%0d required=0", timestamp); end
    exp_q.delete();
    tick();
    reset = 1'b0;
    push_hdr(32'd0);
    for (int k = 1; k <= N; k++) exp_q.push_back(16'(16'h0A00 + k));
    drive(1'b1, 1'b1, 16'h0A01);
    for (int k = 2; k <= N; k++) drive(1'b0, 1'b1, 16'(16'h0A00 + k));
    wait_drain("midrst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired required=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_normal();
    test_consecutive();
    test_short();
    test_extra();
    test_gating();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
